rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter for one register-file write port (single-cycle req0 vs multi-cycle req1).
// Optional busy-register scoreboard with decode stall, enabled by defining RF_SCOREBOARD_EN.
module rf_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [4:0]      req0_rd,
    input  logic [XLEN-1:0] req0_data,
    input  logic [XLEN-1:0] req0_pc,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [4:0]      req1_rd,
    input  logic [XLEN-1:0] req1_data,
    input  logic [XLEN-1:0] req1_pc,
    output logic            rf_we,
    output logic [4:0]      rf_a3,
    output logic [XLEN-1:0] rf_wd,
    output logic [XLEN-1:0] rf_pc,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            stall,
    output logic [31:0]     pending
);

    logic            rr_last;
    logic            xfer0;
    logic            xfer1;
    logic            xfer;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic [XLEN-1:0] win_pc;

    // rr_last = 1 means req1 won the previous transfer, so req0 gets priority on a tie
    assign req0_ready = req0_valid & (~req1_valid | rr_last);
    assign req1_ready = req1_valid & (~req0_valid | ~rr_last);
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;
    assign xfer       = xfer0 | xfer1;

    always_comb begin
        win_rd   = req0_rd;
        win_data = req0_data;
        win_pc   = req0_pc;
        if (xfer1) begin
            win_rd   = req1_rd;
            win_data = req1_data;
            win_pc   = req1_pc;
        end
    end

    // Writes to x0 are accepted but never strobed into the register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we   <= 1'b0;
            rf_a3   <= '0;
            rf_wd   <= '0;
            rf_pc   <= '0;
            rr_last <= 1'b0;
        end else begin
            rf_we <= xfer & (win_rd != 5'd0);
            if (xfer) begin
                rf_a3   <= win_rd;
                rf_wd   <= win_data;
                rf_pc   <= win_pc;
                rr_last <= xfer1;
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    logic [31:0] pend_q;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && issue_rd != 5'd0) set_vec[issue_rd] = 1'b1;
        if (xfer1) clr_vec[req1_rd] = 1'b1;
    end

    // Set is applied after clear so a same-cycle reissue keeps the register busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_vec) | set_vec;
        end
    end

    assign pending = pend_q;
    assign stall   = ((rs1 != 5'd0) & pend_q[rs1])
                   | ((rs2 != 5'd0) & pend_q[rs2])
                   | (issue_valid & (issue_rd != 5'd0) & pend_q[issue_rd]);
`else
    logic unused_sb;

    assign unused_sb = &{1'b0, issue_valid, issue_rd, rs1, rs2};
    assign pending   = '0;
    assign stall     = 1'b0;
`endif

endmodule
